// File: rtl/pwm_audio_dac.sv
// Multi-channel PWM / first-order sigma-delta audio DAC with double-buffered samples.
// Define PWM_AUDIO_DAC_SD_EN to build the sigma-delta datapath; otherwise `mode` is ignored.
module pwm_audio_dac #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         mode,
  input  logic [CHANNELS*WIDTH-1:0]    sample,
  input  logic                         sample_valid,
  output logic                         sample_ready,
  output logic [CHANNELS-1:0]          pwm_out,
  output logic                         period_strobe,
  output logic                         underrun
);

  // Period is 2^WIDTH - 1 clocks, so the last count value is 2^WIDTH - 2.
  localparam logic [WIDTH-1:0] LAST_COUNT = WIDTH'((1 << WIDTH) - 2);

  logic [WIDTH-1:0]    count;
  logic [WIDTH-1:0]    shadow [CHANNELS];
  logic [WIDTH-1:0]    active [CHANNELS];
  logic                shadow_full;
  logic                mode_q;
  logic                boundary;
  logic                take;
  logic                load;
  logic [CHANNELS-1:0] sd_carry;
  logic [CHANNELS-1:0] pwm_next;

  assign boundary     = enable && (count == LAST_COUNT);
  assign take         = sample_valid && !shadow_full;
  // While disabled the shadow drains straight into active so re-enable starts fresh.
  assign load         = shadow_full && (boundary || !enable);
  assign sample_ready = !shadow_full;

`ifdef PWM_AUDIO_DAC_SD_EN
  logic [WIDTH-1:0] acc [CHANNELS];
  logic             acc_clear;

  assign acc_clear = !enable || (load && (mode != mode_q));

  for (genvar c = 0; c < CHANNELS; c++) begin : g_sd
    logic [WIDTH:0] sum;
    assign sum         = {1'b0, acc[c]} + {1'b0, active[c]};
    assign sd_carry[c] = sum[WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) acc[c] <= '0;
    end else begin
      if (load) mode_q <= mode;
      for (int c = 0; c < CHANNELS; c++) begin
        if (acc_clear)   acc[c] <= '0;
        else if (mode_q) acc[c] <= acc[c] + active[c];
      end
    end
  end
`else
  logic unused_mode;

  assign unused_mode = mode;
  assign mode_q      = 1'b0;
  assign sd_carry    = '0;
`endif

  always_comb begin
    // NOTE: every bit of pwm_next is assigned on every pass, so no latch is inferred.
    pwm_next = '0;
    for (int c = 0; c < CHANNELS; c++)
      pwm_next[c] = mode_q ? sd_carry[c] : (count < active[c]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the sample arrays are a handful of flops, not RAM, so they reset like any register.
      for (int c = 0; c < CHANNELS; c++) begin
        shadow[c] <= '0;
        active[c] <= '0;
      end
      shadow_full   <= 1'b0;
      count         <= '0;
      pwm_out       <= '0;
      period_strobe <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      if (take) begin
        for (int c = 0; c < CHANNELS; c++) shadow[c] <= sample[c*WIDTH +: WIDTH];
        shadow_full <= 1'b1;
      end else if (load) begin
        shadow_full <= 1'b0;
      end

      if (load)
        for (int c = 0; c < CHANNELS; c++) active[c] <= shadow[c];

      if (enable) begin
        count         <= boundary ? '0 : count + WIDTH'(1);
        pwm_out       <= pwm_next;
        period_strobe <= boundary;
        underrun      <= boundary && !shadow_full;
      end else begin
        count         <= '0;
        pwm_out       <= '0;
        period_strobe <= 1'b0;
        underrun      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_audio_dac.sv
// Directed bench for pwm_audio_dac (WIDTH=8, CHANNELS=2): duty tables, double buffering,
// underrun, sigma-delta patterns, enable gating and asynchronous reset.
module tb_pwm_audio_dac;

  localparam int WIDTH = 8;
  localparam int CH    = 2;
  localparam int P     = 255;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            enable = 1'b0;
  logic            mode = 1'b0;
  logic [CH*WIDTH-1:0] sample = '0;
  logic            sample_valid = 1'b0;
  logic            sample_ready;
  logic [CH-1:0]   pwm_out;
  logic            period_strobe;
  logic            underrun;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] s1;
    logic [7:0] s0;
    int         e0;
    int         e1;
  } vec_t;

  vec_t tbl [4];

  pwm_audio_dac #(.WIDTH(WIDTH), .CHANNELS(CH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .mode         (mode),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .pwm_out      (pwm_out),
    .period_strobe(period_strobe),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Runs exactly P cycles; optionally offers a vector before cycle offer_at+1.
  task automatic run_period(input string tag, input int offer_at, input logic [7:0] s1,
                            input logic [7:0] s0, input logic m, input int e0, input int e1,
                            input int e_under, input bit chk_first, input logic [7:0] ef0,
                            input logic [7:0] ef1);
    int hi0 = 0, hi1 = 0, strobe_at = -1, n_strobe = 0, n_under = 0;
    logic rdy_post = 1'b1, rdy_pre = 1'b1, rdy_end = 1'b0;
    logic [7:0] f0 = '0, f1 = '0;
    for (int i = 1; i <= P; i++) begin
      if (i - 1 == offer_at) begin
        sample       = {s1, s0};
        mode         = m;
        sample_valid = 1'b1;
      end
      tick();
      sample_valid = 1'b0;
      if (pwm_out[0]) hi0++;
      if (pwm_out[1]) hi1++;
      if (i <= 8) begin
        f0[i-1] = pwm_out[0];
        f1[i-1] = pwm_out[1];
      end
      if (period_strobe) begin
        n_strobe++;
        if (strobe_at < 0) strobe_at = i;
      end
      if (underrun) n_under++;
      if (i == offer_at + 1) rdy_post = sample_ready;
      if (i == P - 1) rdy_pre = sample_ready;
      if (i == P) rdy_end = sample_ready;
    end
    check({tag, " high0"}, hi0, e0);
    check({tag, " high1"}, hi1, e1);
    check({tag, " strobe_pos"}, strobe_at, P);
    check({tag, " strobe_cnt"}, n_strobe, 1);
    check({tag, " underrun_cnt"}, n_under, e_under);
    if (offer_at >= 0) begin
      check({tag, " ready_after_hs"}, int'(rdy_post), 0);
      check({tag, " ready_before_bnd"}, int'(rdy_pre), 0);
      check({tag, " ready_at_cnt0"}, int'(rdy_end), 1);
    end
    if (chk_first) begin
      check({tag, " first8_ch0"}, int'(f0), int'(ef0));
      check({tag, " first8_ch1"}, int'(f1), int'(ef1));
    end
  endtask

  initial begin
    int e0, e1;
    logic [7:0] sd0, sd1;
    int sd_hi0, sd_hi1;

    tbl[0] = '{s1: 8'h80, s0: 8'h00, e0: 0,   e1: 128};
    tbl[1] = '{s1: 8'h01, s0: 8'hFE, e0: 254, e1: 1};
    tbl[2] = '{s1: 8'h00, s0: 8'hFF, e0: 255, e1: 0};
    tbl[3] = '{s1: 8'hC3, s0: 8'h10, e0: 16,  e1: 195};

`ifdef PWM_AUDIO_DAC_SD_EN
    sd0 = 8'hAA; sd1 = 8'h88; sd_hi0 = 127; sd_hi1 = 63;
`else
    sd0 = 8'hFF; sd1 = 8'hFF; sd_hi0 = 128; sd_hi1 = 64;
`endif

    // Reset values
    #2 rst_n = 1'b0;
    tick();
    check("rst pwm_out", int'(pwm_out), 0);
    check("rst ready", int'(sample_ready), 1);
    check("rst strobe", int'(period_strobe), 0);
    check("rst underrun", int'(underrun), 0);
    rst_n = 1'b1;
    tick();

    // Load {ch1=FF, ch0=40} while disabled: transfers to active on the next edge
    sample = {8'hFF, 8'h40};
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    check("dis hs ready_low", int'(sample_ready), 0);
    tick();
    check("dis transfer ready_high", int'(sample_ready), 1);
    check("dis pwm_zero", int'(pwm_out), 0);

    // Each period offers the next table vector mid-period; duty seen is the previous one
    enable = 1'b1;
    e0 = 64;
    e1 = 255;
    for (int k = 0; k < 4; k++) begin
      run_period($sformatf("tbl%0d", k), 100, tbl[k].s1, tbl[k].s0, 1'b0, e0, e1, 0,
                 1'b0, 8'h00, 8'h00);
      e0 = tbl[k].e0;
      e1 = tbl[k].e1;
    end

    // No handshake: underrun pulses with the strobe and the duty repeats
    run_period("under_a", -1, 8'h00, 8'h00, 1'b0, e0, e1, 1, 1'b0, 8'h00, 8'h00);
    run_period("under_b", -1, 8'h00, 8'h00, 1'b0, e0, e1, 1, 1'b0, 8'h00, 8'h00);

    // Request sigma-delta with {ch1=40, ch0=80}; PWM-only builds keep producing PWM
    run_period("sd_load", 10, 8'h40, 8'h80, 1'b1, 16, 195, 0, 1'b0, 8'h00, 8'h00);
    run_period("sd_run", -1, 8'h00, 8'h00, 1'b1, sd_hi0, sd_hi1, 1, 1'b1, sd0, sd1);

    // Enable gating mid-period, with a vector accepted while disabled
    for (int i = 0; i < 20; i++) tick();
    enable = 1'b0;
    tick();
    check("gate pwm_zero", int'(pwm_out), 0);
    check("gate strobe_zero", int'(period_strobe), 0);
    sample = {8'h20, 8'h03};
    mode = 1'b0;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    check("gate hs ready_low", int'(sample_ready), 0);
    tick();
    check("gate transfer ready_high", int'(sample_ready), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("gate idle%0d pwm", i), int'(pwm_out), 0);
    end
    enable = 1'b1;
    run_period("reenable", -1, 8'h00, 8'h00, 1'b0, 3, 32, 1, 1'b1, 8'h07, 8'hFF);

    // Asynchronous reset mid-period with the shadow full and ch1 high
    for (int i = 0; i < 5; i++) tick();
    sample = {8'h55, 8'h55};
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    check("pre_rst ready_low", int'(sample_ready), 0);
    check("pre_rst pwm", int'(pwm_out), 2);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst pwm_out", int'(pwm_out), 0);
    check("async_rst ready", int'(sample_ready), 1);
    check("async_rst strobe", int'(period_strobe), 0);
    check("async_rst underrun", int'(underrun), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("post_rst pwm_out", int'(pwm_out), 0);
    check("post_rst ready", int'(sample_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
